// File: rtl/lut_pkg.sv
// Shared definitions for the runtime-programmable neuron LUT bank.
//
// Contents:
//   IN_BITS / WORD_W  default neuron address width and config word width
//   calc_wpn          config words needed to fill one neuron table
//   calc_total_words  config words needed to fill the whole bank
//   calc_idx_w        width of a word index inside one neuron (minimum 1)
//   state_t           loader FSM states
package lut_pkg;

    localparam int IN_BITS = 6;
    localparam int WORD_W  = 8;

    // WORD_W has to divide the table depth exactly, otherwise the last word
    // of a neuron would spill into the next neuron's table.
    function automatic int calc_wpn(input int in_bits, input int word_w);
        return (1 << in_bits) / word_w;
    endfunction

    function automatic int calc_total_words(input int n_neurons, input int in_bits,
                                            input int word_w);
        return n_neurons * calc_wpn(in_bits, word_w);
    endfunction

    // A neuron filled by a single word still needs a 1-bit index port.
    function automatic int calc_idx_w(input int wpn);
        return (wpn > 1) ? $clog2(wpn) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: a 2^IN_BITS x 1 distributed RAM.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, clears every table bit
//   we     write enable for one config word
//   widx   which WORD_W-bit slice of the table the word lands in
//   wdata  table bits, bit j goes to entry widx*WORD_W + j
//   raddr  lookup address (unsigned)
//   rdata  asynchronous read of table[raddr]; the parent registers it
module lut_neuron_ram
    import lut_pkg::*;
#(
    parameter int  IN_BITS = lut_pkg::IN_BITS,
    parameter int  WORD_W  = lut_pkg::WORD_W,
    localparam int DEPTH   = 1 << IN_BITS,
    localparam int WIDX_W  = calc_idx_w(calc_wpn(IN_BITS, WORD_W))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [WIDX_W-1:0]   widx,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic                rdata
);

    logic [DEPTH-1:0] mem;

    // The table is held as one flat vector so a whole config word lands in a
    // single indexed part-select. The reset clear is what lets a bank come
    // up in a known all-zero state without a full load.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[int'(widx) * WORD_W +: WORD_W] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_bank_loader.sv
// Bank of N_NEURONS runtime-loadable neuron LUTs with a streaming loader.
//
// A table load starts with a cfg_start pulse, then accepts TOTAL_WORDS config
// words over cfg_valid/cfg_ready. Word k fills neuron k/WPN, entries
// (k%WPN)*WORD_W .. +WORD_W-1. After the last word, cfg_done pulses and the
// bank serves one-cycle-latency lookups for a whole layer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start           pulse that begins or restarts a load
//   cfg_valid/ready     config word handshake, cfg_data holds the table bits
//   cfg_done            one-cycle pulse once the last word is written
//   in_valid/ready      lookup request handshake
//   in_data             neuron n address at in_data[n*IN_BITS +: IN_BITS]
//   out_valid/ready     lookup result handshake (single-entry register)
//   out_data            bit n = table_n[address_n]
module lut_bank_loader
    import lut_pkg::*;
#(
    parameter int IN_BITS   = lut_pkg::IN_BITS,
    parameter int N_NEURONS = 16,
    parameter int WORD_W    = lut_pkg::WORD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [WORD_W-1:0]             cfg_data,
    output logic                          cfg_done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS-1:0]          out_data
);

    localparam int WPN         = calc_wpn(IN_BITS, WORD_W);
    localparam int TOTAL_WORDS = calc_total_words(N_NEURONS, IN_BITS, WORD_W);
    localparam int WIDX_W      = calc_idx_w(WPN);
    // One spare bit keeps WPN itself representable when there is one neuron.
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);

    localparam logic [CNT_W-1:0] WPN_C  = CNT_W'(WPN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL_WORDS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    word_cnt;
    logic [CNT_W-1:0]    cnt_d;
    logic                done_d;

    logic                cfg_fire;
    logic                in_fire;
    logic [CNT_W-1:0]    neuron_sel;
    logic [WIDX_W-1:0]   word_idx;
    logic [N_NEURONS-1:0] lookup_bits;

    // Next-state and handshake logic. cfg_ready is masked by cfg_start so a
    // restart always wins over a word offered in the same cycle; that word is
    // simply not accepted. in_ready only depends on the output register, so
    // a lookup can still be taken in the cycle cfg_start arrives in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = word_cnt;
        done_d    = 1'b0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                cfg_ready = !cfg_start;
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    if (word_cnt == LAST_C) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = word_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, word counter and the registered cfg_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_cnt <= '0;
            cfg_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_cnt <= cnt_d;
            cfg_done <= done_d;
        end
    end

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign in_fire    = in_valid && in_ready;
    assign neuron_sel = word_cnt / WPN_C;
    assign word_idx   = WIDX_W'(word_cnt % WPN_C);

    // One RAM per neuron; all share the write data and word index, and only
    // the neuron addressed by the current word count gets the write enable.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        lut_neuron_ram #(
            .IN_BITS (IN_BITS),
            .WORD_W  (WORD_W)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (cfg_fire && (neuron_sel == CNT_W'(n))),
            .widx  (word_idx),
            .wdata (cfg_data),
            .raddr (in_data[n*IN_BITS +: IN_BITS]),
            .rdata (lookup_bits[n])
        );
    end

    // Single-entry result register. A held result drains on out_ready in any
    // state, so a lookup in flight when a reload starts is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= lookup_bits;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_bank_loader.sv
// Directed self-checking bench for lut_bank_loader (16 neurons x 6 inputs,
// 8-bit config words, 128 words per load).
module tb_lut_bank_loader;

    localparam int N     = 16;
    localparam int IB    = 6;
    localparam int WW    = 8;
    localparam int WPN_T = 8;
    localparam int TOTAL = 128;
    localparam int OW    = 96;

    // Upper neuron address fields during lookups; only neuron 0 is swept.
    localparam logic [N*IB-1:0] IN_PATTERN = 96'h9C3_5A1E_77D2_4B60_F18A_2C45;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WW-1:0]     cfg_data;
    logic              cfg_done;
    logic              in_valid;
    logic              in_ready;
    logic [N*IB-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;

    int compared   = 0;
    int mismatched = 0;

    lut_bank_loader #(
        .IN_BITS   (IB),
        .N_NEURONS (N),
        .WORD_W    (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [OW-1:0] observed,
                               input logic [OW-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [WW-1:0] data, input logic iv,
                                 input logic [IB-1:0] a0, input logic ordy);
        cfg_start = start;
        cfg_valid = valid;
        cfg_data  = data;
        in_valid  = iv;
        in_data   = {IN_PATTERN[N*IB-1:IB], a0};
        out_ready = ordy;
        #1;
    endtask

    task automatic startLoad(input logic with_word);
        applyStimulus(1'b1, with_word, 8'hA5, 1'b0, 6'd0, out_ready);
        checkOutput("cfg_ready_at_start", OW'(cfg_ready), OW'(1'b0));
        tick;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, out_ready);
    endtask

    task automatic loadWords(input int count, input logic [WW-1:0] w0,
                             input logic [WW-1:0] wr, input logic expect_done);
        for (int k = 0; k < count; k++) begin
            applyStimulus(1'b0, 1'b1, (k < WPN_T) ? w0 : wr, 1'b0, 6'd0, out_ready);
            checkOutput("cfg_ready_load", OW'(cfg_ready), OW'(1'b1));
            checkOutput("in_ready_load", OW'(in_ready), OW'(1'b0));
            checkOutput("cfg_done_early", OW'(cfg_done), OW'(1'b0));
            tick;
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, out_ready);
        checkOutput("cfg_done_after_load", OW'(cfg_done), OW'(expect_done));
        if (expect_done) begin
            tick;
            checkOutput("cfg_done_one_cycle", OW'(cfg_done), OW'(1'b0));
        end
    endtask

    task automatic lookup(input logic [IB-1:0] a0, input logic [N-1:0] expv,
                          input string tag);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, a0, 1'b1);
        checkOutput({tag, "_in_ready"}, OW'(in_ready), OW'(1'b1));
        tick;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
        checkOutput({tag, "_valid"}, OW'(out_valid), OW'(1'b1));
        checkOutput(tag, OW'(out_data), OW'(expv));
        tick;
        checkOutput({tag, "_drained"}, OW'(out_valid), OW'(1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_cfg_ready", OW'(cfg_ready), OW'(1'b0));
        checkOutput("rst_cfg_done", OW'(cfg_done), OW'(1'b0));
        checkOutput("rst_in_ready", OW'(in_ready), OW'(1'b0));
        checkOutput("rst_out_valid", OW'(out_valid), OW'(1'b0));
        checkOutput("rst_out_data", OW'(out_data), OW'(16'h0000));

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd5, 1'b1);
        checkOutput("idle_in_ready", OW'(in_ready), OW'(1'b0));
        tick;
        checkOutput("idle_no_result", OW'(out_valid), OW'(1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1);

        $display("[TB] full load of zeros");
        startLoad(1'b0);
        loadWords(TOTAL, 8'h00, 8'h00, 1'b1);
        lookup(6'd5, 16'h0000, "zero_table");

        $display("[TB] neuron 0 = 0x77, others = 0xFF");
        startLoad(1'b0);
        loadWords(TOTAL, 8'h77, 8'hFF, 1'b1);
        lookup(6'b000011, 16'hFFFE, "n0_addr3");
        lookup(6'b000001, 16'hFFFF, "n0_addr1");
        lookup(6'b111111, 16'hFFFE, "n0_addr63");
        lookup(6'b101010, 16'hFFFF, "n0_addr42");

        $display("[TB] backpressure and back-to-back");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd3, 1'b0);
        checkOutput("bp_in_ready_empty", OW'(in_ready), OW'(1'b1));
        tick;
        checkOutput("bp_first_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("bp_first_data", OW'(out_data), OW'(16'hFFFE));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 1'b0);
        checkOutput("bp_in_ready_full", OW'(in_ready), OW'(1'b0));
        tick;
        checkOutput("bp_hold_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("bp_hold_data", OW'(out_data), OW'(16'hFFFE));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 1'b1);
        checkOutput("b2b_in_ready_1", OW'(in_ready), OW'(1'b1));
        tick;
        checkOutput("b2b_valid_1", OW'(out_valid), OW'(1'b1));
        checkOutput("b2b_data_1", OW'(out_data), OW'(16'hFFFF));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd63, 1'b1);
        checkOutput("b2b_in_ready_2", OW'(in_ready), OW'(1'b1));
        tick;
        checkOutput("b2b_valid_2", OW'(out_valid), OW'(1'b1));
        checkOutput("b2b_data_2", OW'(out_data), OW'(16'hFFFE));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
        tick;
        checkOutput("b2b_drained", OW'(out_valid), OW'(1'b0));

        $display("[TB] restart after 50 words");
        startLoad(1'b0);
        loadWords(50, 8'h00, 8'h00, 1'b0);
        startLoad(1'b1);
        loadWords(TOTAL, 8'hFF, 8'hFF, 1'b1);
        lookup(6'd3, 16'hFFFF, "ones_addr3");
        lookup(6'd0, 16'hFFFF, "ones_addr0");

        $display("[TB] reload with a pending result");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd7, 1'b0);
        tick;
        checkOutput("pend_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("pend_data", OW'(out_data), OW'(16'hFFFF));
        startLoad(1'b0);
        checkOutput("pend_load_in_ready", OW'(in_ready), OW'(1'b0));
        checkOutput("pend_load_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("pend_load_data", OW'(out_data), OW'(16'hFFFF));
        loadWords(TOTAL, 8'h00, 8'hFF, 1'b1);
        checkOutput("pend_after_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("pend_after_data", OW'(out_data), OW'(16'hFFFF));
        checkOutput("pend_after_in_ready", OW'(in_ready), OW'(1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
        checkOutput("pend_release_in_ready", OW'(in_ready), OW'(1'b1));
        tick;
        checkOutput("pend_drained", OW'(out_valid), OW'(1'b0));
        lookup(6'd3, 16'hFFFE, "reload_addr3");
        lookup(6'd0, 16'hFFFE, "reload_addr0");

        $display("[TB] reset during load");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd9, 1'b0);
        tick;
        checkOutput("prerst_valid", OW'(out_valid), OW'(1'b1));
        checkOutput("prerst_data", OW'(out_data), OW'(16'hFFFE));
        startLoad(1'b0);
        loadWords(20, 8'h12, 8'h34, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h56, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0);
        checkOutput("midrst_cfg_ready", OW'(cfg_ready), OW'(1'b0));
        checkOutput("midrst_in_ready", OW'(in_ready), OW'(1'b0));
        checkOutput("midrst_out_valid", OW'(out_valid), OW'(1'b0));
        checkOutput("midrst_out_data", OW'(out_data), OW'(16'h0000));
        checkOutput("midrst_cfg_done", OW'(cfg_done), OW'(1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd3, 1'b1);
        checkOutput("midrst_lookup_in_ready", OW'(in_ready), OW'(1'b0));
        tick;
        checkOutput("midrst_lookup_ignored", OW'(out_valid), OW'(1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
